alu_writeback_stage: RTL and testbench

// - Pipeline stage directly downstream of the ALU. Registers ALU result and Z/N, holds the

---
 rtl/alu_stage_pkg.sv | 24 ++
 rtl/alu_writeback_stage_skid.sv | 75 +++++++
 rtl/alu_writeback_stage.sv | 74 +++++++
 tb/tb_alu_writeback_stage.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/alu_stage_pkg.sv
// Shared types and constants for the ALU write-back stage.
package alu_stage_pkg;

  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_REG_ADDR_W = 6;
  localparam int unsigned DEF_TGT_W      = 32;

  // Bit positions inside the 2-bit architectural flag vector
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;

  typedef struct packed {
    logic [DEF_DATA_W-1:0]     result;
    logic [DEF_REG_ADDR_W-1:0] rd;
    logic                      wr_en;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SKID_EMPTY,
    SKID_ONE,
    SKID_TWO
  } skid_state_t;

endpackage

// File: rtl/alu_writeback_stage_skid.sv
// Two-entry skid buffer; in_ready is registered so upstream never sees out_ready combinationally.
module skid_buffer_2
  import alu_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  skid_state_t      state, state_next;
  logic [WIDTH-1:0] head, head_next;
  logic [WIDTH-1:0] tail, tail_next;
  logic             ready_next;
  logic             accept, drain;

  assign out_valid = (state != SKID_EMPTY);
  assign out_data  = head;
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_comb begin
    state_next = state;
    head_next  = head;
    tail_next  = tail;
    unique case (state)
      SKID_EMPTY: begin
        if (accept) begin
          head_next  = in_data;
          state_next = SKID_ONE;
        end
      end
      SKID_ONE: begin
        unique case ({accept, drain})
          2'b10: begin
            tail_next  = in_data;
            state_next = SKID_TWO;
          end
          2'b01: state_next = SKID_EMPTY;
          2'b11: head_next = in_data;
          default: ;
        endcase
      end
      SKID_TWO: begin
        if (drain) begin
          head_next  = tail;
          state_next = SKID_ONE;
        end
      end
      default: state_next = SKID_EMPTY;
    endcase
    ready_next = (state_next != SKID_TWO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SKID_EMPTY;
      head     <= '0;
      tail     <= '0;
      in_ready <= 1'b0;
    end else begin
      state    <= state_next;
      head     <= head_next;
      tail     <= tail_next;
      in_ready <= ready_next;
    end
  end

endmodule

// File: rtl/alu_writeback_stage.sv
// Post-ALU stage: buffers write-back entries, holds Z/N flags and resolves BRZ/BRN branches.
module alu_writeback_stage
  import alu_stage_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int unsigned TGT_W      = DEF_TGT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_result,
  input  logic                  in_z,
  input  logic                  in_n,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_wr_en,
  input  logic                  in_set_flags,
  input  logic                  in_br_z,
  input  logic                  in_br_n,
  input  logic [TGT_W-1:0]      in_target,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_result,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_wr_en,
  output logic                  flag_z,
  output logic                  flag_n,
  output logic                  br_taken,
  output logic [TGT_W-1:0]      br_target
);

  localparam int unsigned ENTRY_W = DATA_W + REG_ADDR_W + 1;

  logic [ENTRY_W-1:0] in_entry, out_entry;
  logic [1:0]         flags;
  logic               accept;

  assign accept   = in_valid & in_ready;
  assign in_entry = {in_result, in_rd, in_wr_en};
  assign {out_result, out_rd, out_wr_en} = out_entry;
  assign flag_z   = flags[FLAG_Z];
  assign flag_n   = flags[FLAG_N];

  skid_buffer_2 #(.WIDTH(ENTRY_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_entry)
  );

  // Branch reads the pre-edge flags, so a same-transfer set_flags cannot affect it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags     <= '0;
      br_taken  <= 1'b0;
      br_target <= '0;
    end else if (accept) begin
      br_taken  <= (in_br_z & flags[FLAG_Z]) | (in_br_n & flags[FLAG_N]);
      br_target <= in_target;
      if (in_set_flags) begin
        flags[FLAG_Z] <= in_z;
        flags[FLAG_N] <= in_n;
      end
    end else begin
      br_taken <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed self-checking bench for alu_writeback_stage.
module tb_alu_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_result;
  logic        in_z, in_n;
  logic [5:0]  in_rd;
  logic        in_wr_en, in_set_flags, in_br_z, in_br_n;
  logic [31:0] in_target;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [5:0]  out_rd;
  logic        out_wr_en, flag_z, flag_n, br_taken;
  logic [31:0] br_target;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_writeback_stage #(.DATA_W(32), .REG_ADDR_W(6), .TGT_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_z(in_z), .in_n(in_n), .in_rd(in_rd),
    .in_wr_en(in_wr_en), .in_set_flags(in_set_flags),
    .in_br_z(in_br_z), .in_br_n(in_br_n), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_wr_en(out_wr_en),
    .flag_z(flag_z), .flag_n(flag_n),
    .br_taken(br_taken), .br_target(br_target)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic [5:0] rd,
                       input logic we, input logic sf, input logic z, input logic n,
                       input logic bz, input logic bn, input logic [31:0] tgt);
    in_valid = v; in_result = res; in_rd = rd; in_wr_en = we; in_set_flags = sf;
    in_z = z; in_n = n; in_br_z = bz; in_br_n = bn; in_target = tgt;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b1;
    drive(0, 32'h0, 6'd0, 0, 0, 0, 0, 0, 0, 32'h0);
    tick(); tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if ({out_result, out_rd, out_wr_en} !== 39'h0) begin errors++; $display("FAIL reset_out_fields got=%h/%h/%b exp=0", out_result, out_rd, out_wr_en); end
    checks++; if ({flag_z, flag_n, br_taken} !== 3'b000) begin errors++; $display("FAIL reset_flags_br got=%b%b%b exp=000", flag_z, flag_n, br_taken); end
    checks++; if (br_target !== 32'h0) begin errors++; $display("FAIL reset_br_target got=%h exp=0", br_target); end
    rst = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_passthrough();
    out_ready = 1'b1;
    drive(1, 32'h0000_0005, 6'd3, 1, 0, 0, 0, 0, 0, 32'h0);
    tick();
    drive(0, 32'h0, 6'd0, 0, 0, 0, 0, 0, 0, 32'h0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pass_valid got=%b exp=1", out_valid); end
    checks++; if (out_result !== 32'h5) begin errors++; $display("FAIL pass_result got=%h exp=5", out_result); end
    checks++; if (out_rd !== 6'd3 || out_wr_en !== 1'b1) begin errors++; $display("FAIL pass_rd_we got=%0d/%b exp=3/1", out_rd, out_wr_en); end
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL pass_br got=%b exp=0", br_taken); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pass_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_flags();
    out_ready = 1'b1;
    drive(1, 32'h0, 6'd1, 1, 1, 1, 0, 0, 0, 32'h0);
    tick();
    checks++; if (flag_z !== 1'b1 || flag_n !== 1'b0) begin errors++; $display("FAIL flags_set got=z%b n%b exp=z1 n0", flag_z, flag_n); end
    drive(1, 32'h0, 6'd0, 0, 0, 0, 0, 1, 0, 32'h40);
    tick();
    drive(0, 32'h0, 6'd0, 0, 0, 0, 0, 0, 0, 32'h0);
    checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL brz_taken got=%b exp=1", br_taken); end
    checks++; if (br_target !== 32'h40) begin errors++; $display("FAIL brz_target got=%h exp=40", br_target); end
    tick();
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL brz_pulse got=%b exp=0", br_taken); end
  endtask

  task automatic test_hazard();
    out_ready = 1'b1;
    drive(1, 32'h1, 6'd2, 1, 1, 0, 0, 0, 0, 32'h0);
    tick();
    checks++; if (flag_z !== 1'b0) begin errors++; $display("FAIL hazard_clear got=%b exp=0", flag_z); end
    drive(1, 32'h0, 6'd2, 1, 1, 1, 0, 1, 0, 32'h99);
    tick();
    drive(0, 32'h0, 6'd0, 0, 0, 0, 0, 0, 0, 32'h0);
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL hazard_br got=%b exp=0", br_taken); end
    checks++; if (flag_z !== 1'b1) begin errors++; $display("FAIL hazard_flag_z got=%b exp=1", flag_z); end
    tick();
  endtask

  task automatic test_negative();
    out_ready = 1'b1;
    drive(1, 32'hFFFF_FFFF, 6'd4, 1, 1, 0, 1, 0, 0, 32'h0);
    tick();
    checks++; if (flag_n !== 1'b1 || flag_z !== 1'b0) begin errors++; $display("FAIL neg_flags got=z%b n%b exp=z0 n1", flag_z, flag_n); end
    drive(1, 32'h0, 6'd0, 0, 0, 0, 0, 0, 1, 32'h80);
    tick();
    checks++; if (br_taken !== 1'b1 || br_target !== 32'h80) begin errors++; $display("FAIL brn_taken got=%b/%h exp=1/80", br_taken, br_target); end
    drive(1, 32'h7, 6'd5, 1, 1, 0, 0, 0, 0, 32'h0);
    tick();
    drive(1, 32'h0, 6'd0, 0, 0, 0, 0, 0, 1, 32'h84);
    tick();
    drive(0, 32'h0, 6'd0, 0, 0, 0, 0, 0, 0, 32'h0);
    checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL brn_not_taken got=%b exp=0", br_taken); end
    tick();
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    drive(1, 32'hA, 6'd10, 1, 0, 0, 0, 0, 0, 32'h0);
    tick();
    checks++; if (out_valid !== 1'b1 || out_result !== 32'hA || in_ready !== 1'b1) begin errors++; $display("FAIL stall_a got=v%b r%h rdy%b exp=v1 rA rdy1", out_valid, out_result, in_ready); end
    drive(1, 32'hB, 6'd11, 0, 0, 0, 0, 0, 0, 32'h0);
    tick();
    checks++; if (in_ready !== 1'b0 || out_result !== 32'hA) begin errors++; $display("FAIL stall_full got=rdy%b r%h exp=rdy0 rA", in_ready, out_result); end
    drive(1, 32'hC, 6'd12, 1, 0, 0, 0, 0, 0, 32'h0);
    tick();
    checks++; if (out_result !== 32'hA || out_rd !== 6'd10 || in_ready !== 1'b0) begin errors++; $display("FAIL stall_hold got=r%h rd%0d rdy%b exp=rA rd10 rdy0", out_result, out_rd, in_ready); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_result !== 32'hB || out_wr_en !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL drain_b got=r%h we%b rdy%b exp=rB we0 rdy1", out_result, out_wr_en, in_ready); end
    tick();
    drive(0, 32'h0, 6'd0, 0, 0, 0, 0, 0, 0, 32'h0);
    checks++; if (out_valid !== 1'b1 || out_result !== 32'hC || out_rd !== 6'd12) begin errors++; $display("FAIL drain_c got=v%b r%h rd%0d exp=v1 rC rd12", out_valid, out_result, out_rd); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1, 32'h11, 6'd7, 1, 1, 0, 1, 0, 0, 32'h0);
    tick();
    drive(1, 32'h22, 6'd8, 1, 0, 0, 0, 0, 1, 32'hC0);
    tick();
    drive(0, 32'h0, 6'd0, 0, 0, 0, 0, 0, 0, 32'h0);
    checks++; if (br_taken !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_pre got=br%b rdy%b exp=br1 rdy0", br_taken, in_ready); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || {out_result, out_rd, out_wr_en} !== 39'h0) begin errors++; $display("FAIL mid_out got=v%b r%h rd%0d we%b exp=0", out_valid, out_result, out_rd, out_wr_en); end
    checks++; if ({flag_z, flag_n, br_taken, in_ready} !== 4'b0000 || br_target !== 32'h0) begin errors++; $display("FAIL mid_flags got=%b%b%b%b t%h exp=0000 t0", flag_z, flag_n, br_taken, in_ready, br_target); end
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_release got=rdy%b v%b exp=rdy1 v0", in_ready, out_valid); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_flags();
    test_hazard();
    test_negative();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
